// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, status codes, register none) and the
// run-state type used by the pipeline control unit.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } run_state_t;

  // Any status that stops the machine: halt, bad address or bad instruction.
  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection for the five-stage Y86-64 pipeline:
// load/use, mispredicted jump and return-in-flight.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  output logic       loaduse,
  output logic       mispred,
  output logic       ret
);

  logic e_is_load;

  assign e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);

  // RNONE never creates a dependency, even if a source is also RNONE.
  assign loaduse = e_is_load && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign mispred = (E_icode == IJXX) && !e_Cnd;

  assign ret = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline control: stall/bubble/set_cc generation plus IDLE/RUN/HALTED
// run-state machine. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipe_control
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [3:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  logic       loaduse, mispred, ret;
  logic       m_exc, w_exc;
  run_state_t state_q, state_nxt;
  logic [3:0] stat_q, stat_nxt;

  pipe_hazard_detect u_hazard (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .loaduse (loaduse),
    .mispred (mispred),
    .ret     (ret)
  );

  assign m_exc = is_exc(m_stat);
  assign w_exc = is_exc(W_stat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_nxt;
      stat_q  <= stat_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    stat_nxt  = stat_q;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    W_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    set_cc    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Flush the pipeline with nops until the processor is started.
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = loaduse || ret;
        D_stall  = loaduse;
        // Load/use takes priority on D so it is never stalled and bubbled together.
        D_bubble = mispred || (ret && !loaduse);
        E_bubble = mispred || loaduse;
        M_bubble = m_exc || w_exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
        if (w_exc) begin
          state_nxt = ST_HALTED;
          stat_nxt  = W_stat;
        end
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign halted   = (state_q == ST_HALTED);
  assign cpu_stat = halted ? stat_q : SAOK;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q, lu_q, mp_q, ret_q;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && !(&v)) return v + CNT_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      lu_q  <= '0;
      mp_q  <= '0;
      ret_q <= '0;
    end else if (state_q == ST_RUN) begin
      cyc_q <= sat_inc(cyc_q, 1'b1);
      lu_q  <= sat_inc(lu_q, loaduse);
      mp_q  <= sat_inc(mp_q, mispred);
      ret_q <= sat_inc(ret_q, ret && !loaduse);
    end
  end

  assign cyc_cnt = cyc_q;
  assign lu_cnt  = lu_q;
  assign mp_cnt  = mp_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed scenarios followed by random stimulus,
// all checked cycle by cycle against a behavioural model.
module tb_pipe_control;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, e_Cnd;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic             F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
  logic [3:0]       cpu_stat;
  logic [CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: 0 = idle, 1 = running, 2 = halted.
  int         mode;
  logic [3:0] lat_stat;
  int         m_cyc, m_lu, m_mp, m_ret;

  always #5 clk = ~clk;

  pipe_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
    .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exc(input logic [3:0] s);
    return s == 4'h2 || s == 4'h3 || s == 4'h4;
  endfunction

  function automatic bit lu_now();
    return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction

  function automatic bit mp_now();
    return E_icode == 4'h7 && !e_Cnd;
  endfunction

  function automatic bit ret_now();
    return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
  endfunction

  task automatic check_outs();
    bit lu, mp, rt, ef, ed, eb, ee, em, ew, ec;
    lu = lu_now(); mp = mp_now(); rt = ret_now();
    if (mode == 1) begin
      ef = lu || rt; ed = lu; ew = exc(W_stat);
      eb = mp || (rt && !lu); ee = mp || lu;
      em = exc(m_stat) || exc(W_stat);
      ec = E_icode == 4'h6 && !exc(m_stat) && !exc(W_stat);
    end else begin
      ef = 1; ed = 0; eb = 1; ee = 1; em = 1; ec = 0;
      ew = (mode == 2);
    end
    chk("F_stall", F_stall, ef);
    chk("D_stall", D_stall, ed);
    chk("W_stall", W_stall, ew);
    chk("D_bubble", D_bubble, eb);
    chk("E_bubble", E_bubble, ee);
    chk("M_bubble", M_bubble, em);
    chk("set_cc", set_cc, ec);
    chk("halted", halted, mode == 2);
    chk("cpu_stat", cpu_stat, (mode == 2) ? lat_stat : 4'h1);
`ifdef PIPE_CTRL_PERF_EN
    chk("cyc_cnt", cyc_cnt, m_cyc);
    chk("lu_cnt", lu_cnt, m_lu);
    chk("mp_cnt", mp_cnt, m_mp);
    chk("ret_cnt", ret_cnt, m_ret);
`else
    chk("cnt_sum", {cyc_cnt, lu_cnt, mp_cnt, ret_cnt}, 0);
`endif
  endtask

  function automatic int sat(input int v, input bit en);
    return (en && v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic update_model();
    if (rst) begin
      mode = 0; lat_stat = 4'h1;
      m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
    end else if (mode == 0) begin
      if (start) mode = 1;
    end else if (mode == 1) begin
      m_cyc = sat(m_cyc, 1);
      m_lu  = sat(m_lu, lu_now());
      m_mp  = sat(m_mp, mp_now());
      m_ret = sat(m_ret, ret_now() && !lu_now());
      if (exc(W_stat)) begin
        mode = 2; lat_stat = W_stat;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic nops();
    start = 0; rst = 0;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1;
    m_stat = 4'h1; W_stat = 4'h1;
  endtask

  function automatic logic [3:0] rnd_icode();
    logic [3:0] tbl [8] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
    return tbl[$urandom_range(7)];
  endfunction

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(4) == 0) ? 4'hF : 4'($urandom_range(3));
  endfunction

  function automatic logic [3:0] rnd_stat(input int odds);
    if ($urandom_range(odds - 1) == 0) return 4'($urandom_range(4, 2));
    return 4'h1;
  endfunction

  initial begin
    nops();
    rst = 1;
    repeat (2) @(posedge clk);
    update_model();
    #1;

    rst = 0;
    repeat (5) tick();
    start = 1; tick(); start = 0;
    tick();

    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; tick();
    E_dstM = 4'hF; tick();
    nops();
    E_icode = 4'h7; e_Cnd = 0; tick();
    e_Cnd = 1; tick();
    nops();
    D_icode = 4'h9; tick();
    D_icode = 4'h1; E_icode = 4'h9; tick();
    E_icode = 4'h1; M_icode = 4'h9; tick();
    D_icode = 4'h9; M_icode = 4'h1; E_icode = 4'h5; E_dstM = 4'h4; d_srcB = 4'h4; tick();
    nops();
    E_icode = 4'h6; tick();
    m_stat = 4'h3; tick();
    m_stat = 4'h1; W_stat = 4'h3; tick();
    W_stat = 4'h1; tick();
    start = 1; tick(); start = 0;
    tick();
    rst = 1; start = 1; tick();
    rst = 0; start = 0; tick();

    start = 1; tick(); start = 0;
    repeat (22) tick();
    rst = 1; tick(); rst = 0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(59) == 0);
      start   = ($urandom_range(7) == 0);
      D_icode = rnd_icode();
      E_icode = rnd_icode();
      M_icode = rnd_icode();
      d_srcA  = rnd_reg();
      d_srcB  = rnd_reg();
      E_dstM  = rnd_reg();
      e_Cnd   = 1'($urandom_range(1));
      m_stat  = rnd_stat(12);
      W_stat  = rnd_stat(40);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
